// File: rtl/firewall_pkg.sv
// Shared types and widths for the firewall enforcement blocks.
package firewall_pkg;

  localparam int WORD_W     = 32;
  localparam int DROP_CNT_W = 16;
  localparam int TIMER_W    = 16;
  localparam int STRIKE_W   = 3;

  typedef enum logic [1:0] {
    ST_PASS     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_BLOCK    = 2'd2,
    ST_COOLDOWN = 2'd3
  } gate_state_t;

  // Terminal count for a timer that runs for n cycles (counts n-1 down to 0).
  function automatic logic [TIMER_W-1:0] cycles_to_tc(input int unsigned n);
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for firewall statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = &value;

  // Count up on inc, hold at all-ones, clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !at_max) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/threat_response_gate.sv
// Enforcement gate: forwards clean words, drops flagged ones, escalates to a
// timed BLOCK that sinks traffic, then a probation COOLDOWN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  PASS     | no strikes, words forwarded
//  ALERT    | 1..LIMIT-1 strikes, clean cycles decay strikes over time
//  BLOCK    | all input sunk and counted as dropped, timer runs down
//  COOLDOWN | strikes cleared, any flagged word re-enters BLOCK
module threat_response_gate
  import firewall_pkg::*;
#(
  parameter int unsigned STRIKE_LIMIT    = 3,
  parameter int unsigned DECAY_CYCLES    = 16,
  parameter int unsigned BLOCK_CYCLES    = 32,
  parameter int unsigned COOLDOWN_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  viol_sig,
  input  logic                  viol_rep,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            state,
  output logic [STRIKE_W-1:0]   strikes,
  output logic                  block_irq,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [STRIKE_W-1:0] STRIKE_LIM  = STRIKE_W'(STRIKE_LIMIT);
  localparam logic [TIMER_W-1:0]  DECAY_TC    = cycles_to_tc(DECAY_CYCLES);
  localparam logic [TIMER_W-1:0]  BLOCK_TC    = cycles_to_tc(BLOCK_CYCLES);
  localparam logic [TIMER_W-1:0]  COOLDOWN_TC = cycles_to_tc(COOLDOWN_CYCLES);

  gate_state_t          state_q, state_d;
  logic [STRIKE_W-1:0]  strikes_q, strikes_d, strikes_inc;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 irq_q, irq_d;

  logic accept;
  logic flagged;
  logic fwd;
  logic drop;
  logic drop_at_max;

  // State, strike count, timer and interrupt pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PASS;
      strikes_q <= '0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      strikes_q <= strikes_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
    end
  end

  // Next-state, strike and timer logic. A flagged word always wins over decay
  // or timer expiry in the same cycle.
  always_comb begin
    state_d     = state_q;
    strikes_d   = strikes_q;
    timer_d     = timer_q;
    irq_d       = 1'b0;
    strikes_inc = strikes_q + 3'd1;
    case (state_q)
      ST_PASS, ST_ALERT: begin
        if (flagged) begin
          strikes_d = strikes_inc;
          if (strikes_inc == STRIKE_LIM) begin
            state_d = ST_BLOCK;
            timer_d = BLOCK_TC;
            irq_d   = 1'b1;
          end else begin
            state_d = ST_ALERT;
            timer_d = '0;
          end
        end else if (state_q == ST_ALERT) begin
          if (timer_q == DECAY_TC) begin
            strikes_d = strikes_q - 3'd1;
            timer_d   = '0;
            if (strikes_q == 3'd1) state_d = ST_PASS;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_BLOCK: begin
        if (flagged) begin
          timer_d = BLOCK_TC;
        end else if (timer_q == '0) begin
          state_d   = ST_COOLDOWN;
          strikes_d = '0;
          timer_d   = COOLDOWN_TC;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (flagged) begin
          state_d = ST_BLOCK;
          timer_d = BLOCK_TC;
          irq_d   = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_PASS;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  // Handshake decode and status outputs; BLOCK sinks input unconditionally.
  always_comb begin
    in_ready  = (state_q == ST_BLOCK) || !out_valid || out_ready;
    accept    = in_valid && in_ready;
    flagged   = accept && (viol_sig || viol_rep);
    fwd       = accept && !flagged && (state_q != ST_BLOCK);
    drop      = flagged || (accept && (state_q == ST_BLOCK));
    state     = state_q;
    strikes   = strikes_q;
    block_irq = irq_q;
  end

  // One-deep output register; a held word keeps draining even inside BLOCK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (fwd) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  sat_counter #(
    .W (DROP_CNT_W)
  ) u_drop_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (drop),
    .clr    (1'b0),
    .value  (drop_count),
    .at_max (drop_at_max)
  );

endmodule

// File: tb/tb_threat_response_gate.sv
// Directed bench for threat_response_gate with a forwarded-word scoreboard.
module tb_threat_response_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        viol_sig;
  logic        viol_rep;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  state;
  logic [2:0]  strikes;
  logic        block_irq;
  logic [15:0] drop_count;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_drop;

  localparam logic [1:0] S_PASS = 2'd0, S_ALERT = 2'd1, S_BLOCK = 2'd2, S_COOL = 2'd3;

  threat_response_gate dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .viol_sig   (viol_sig),
    .viol_rep   (viol_rep),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state      (state),
    .strikes    (strikes),
    .block_irq  (block_irq),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of input; push the word when it is expected at the output.
  task automatic step(input logic [31:0] d, input logic v, input logic s,
                      input logic r, input logic push);
    in_data  = d;
    in_valid = v;
    viol_sig = s;
    viol_rep = r;
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic three_flags();
    for (int k = 0; k < 3; k++) begin
      step(32'hBAD0_0000 + 32'(k), 1'b1, 1'b0, 1'b1, 1'b0);
      exp_drop++;
    end
  endtask

  // Monitor: inputs are driven 2ns after posedge, so at negedge the handshake
  // for the coming edge is settled.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got %h expected no word", out_data);
      end else begin
        check("sb_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    viol_sig  = 1'b0;
    viol_rep  = 1'b0;
    out_ready = 1'b1;
    exp_drop  = '0;
    @(posedge clk);
    #2;
    check("rst_state", 32'(state), 32'(S_PASS));
    check("rst_strikes", 32'(strikes), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_irq", 32'(block_irq), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: clean stream with one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      step(32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      check("t1_latency_valid", 32'(out_valid), 32'd1);
      check("t1_latency_data", out_data, 32'(i));
    end
    idle(2);
    check("t1_state", 32'(state), 32'(S_PASS));
    check("t1_drops", 32'(drop_count), 32'd0);

    // 2: signature hit is dropped, strike decays after 16 clean cycles
    step(32'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'hCAFEBABE, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_drop++;
    check("t2_state_alert", 32'(state), 32'(S_ALERT));
    check("t2_strikes", 32'(strikes), 32'd1);
    check("t2_drops", 32'(drop_count), 32'(exp_drop));
    step(32'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(14);
    check("t2_still_alert", 32'(state), 32'(S_ALERT));
    check("t2_still_strike", 32'(strikes), 32'd1);
    idle(1);
    check("t2_decay_pass", 32'(state), 32'(S_PASS));
    check("t2_decay_strikes", 32'(strikes), 32'd0);

    // 3: three repeat hits escalate to BLOCK, then COOLDOWN, then PASS
    step(32'hBAD0_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_irq_1st", 32'(block_irq), 32'd0);
    step(32'hBAD0_0001, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_irq_2nd", 32'(block_irq), 32'd0);
    check("t3_strikes2", 32'(strikes), 32'd2);
    step(32'hBAD0_0002, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_drop += 16'd3;
    check("t3_irq_3rd", 32'(block_irq), 32'd1);
    check("t3_block", 32'(state), 32'(S_BLOCK));
    check("t3_strikes3", 32'(strikes), 32'd3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    #1;
    check("t3_block_sink_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      exp_drop++;
      if (i == 0) check("t3_irq_once", 32'(block_irq), 32'd0);
    end
    out_ready = 1'b1;
    check("t3_no_forward", 32'(out_valid), 32'd0);
    check("t3_drops", 32'(drop_count), 32'(exp_drop));
    idle(21);
    check("t3_block_last", 32'(state), 32'(S_BLOCK));
    idle(1);
    check("t3_cooldown", 32'(state), 32'(S_COOL));
    check("t3_cool_strikes", 32'(strikes), 32'd0);
    idle(63);
    check("t3_cool_last", 32'(state), 32'(S_COOL));
    idle(1);
    check("t3_pass", 32'(state), 32'(S_PASS));

    // 4: flagged word in COOLDOWN re-enters BLOCK with a full timer
    three_flags();
    idle(32);
    check("t4_cooldown", 32'(state), 32'(S_COOL));
    idle(5);
    step(32'hDEAD0004, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_drop++;
    check("t4_reblock", 32'(state), 32'(S_BLOCK));
    check("t4_irq", 32'(block_irq), 32'd1);
    idle(31);
    check("t4_block_last", 32'(state), 32'(S_BLOCK));
    idle(1);
    check("t4_cooldown2", 32'(state), 32'(S_COOL));
    check("t4_drops", 32'(drop_count), 32'(exp_drop));
    idle(64);
    check("t4_pass", 32'(state), 32'(S_PASS));

    // 5: backpressure holds one word, no loss or duplication on release
    out_ready = 1'b0;
    step(32'h50, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_data  = 32'h51;
      in_valid = 1'b1;
      #1;
      check("t5_stall_ready", 32'(in_ready), 32'd0);
      step(32'h51, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("t5_held", out_data, 32'h50);
    out_ready = 1'b1;
    step(32'h51, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'h52, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'h53, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);

    // 6: reset mid-BLOCK, then reset with a held word
    three_flags();
    idle(5);
    check("t6_in_block", 32'(state), 32'(S_BLOCK));
    rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(state), 32'(S_PASS));
    check("t6_rst_strikes", 32'(strikes), 32'd0);
    check("t6_rst_drops", 32'(drop_count), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_irq", 32'(block_irq), 32'd0);
    rst = 1'b0;
    exp_drop = '0;
    out_ready = 1'b0;
    step(32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_held_word", out_data, 32'h66);
    rst = 1'b1;
    #1;
    check("t6_held_discard_v", 32'(out_valid), 32'd0);
    check("t6_held_discard_d", out_data, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step(32'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_fwd_data", out_data, 32'h77);
    check("t6_fwd_state", 32'(state), 32'(S_PASS));
    idle(3);
    check("t6_drops_after", 32'(drop_count), 32'(exp_drop));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
